// File: rtl/ml_vec_driver.sv
// rtl/ml_vec_driver.sv - four-phase dual-rail word injector/collector for a Morphle Logic yellow-cell array
module ml_vec_driver #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic [1:0]           res_err,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   ml_drv,
  input  logic [2*WIDTH-1:0]   ml_rsp
);

  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  logic [1:0]         state;
  logic [TW-1:0]      timer;
  logic [2*WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [2*WIDTH-1:0] rs;
  logic               any_ill;
  logic               all_full;
  logic               all_empty;
  logic               timeout_hit;
  logic [WIDTH-1:0]   rs_hi;
  logic [2*WIDTH-1:0] drv_word;

  // ml_rsp is asynchronous to clk; every bit goes through its own flop chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ml_rsp;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign rs = sync_q[SYNC_STAGES-1];

  always_comb begin
    any_ill   = 1'b0;
    all_full  = 1'b1;
    all_empty = 1'b1;
    rs_hi     = '0;
    drv_word  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rs[2*i +: 2] == 2'b11) any_ill = 1'b1;
      if (!((rs[2*i +: 2] == 2'b01) || (rs[2*i +: 2] == 2'b10))) all_full = 1'b0;
      if (rs[2*i +: 2] != 2'b00) all_empty = 1'b0;
      rs_hi[i]          = rs[2*i+1];
      drv_word[2*i +: 2] = in_data[i] ? 2'b10 : 2'b01;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (timer == TIMER_LAST);

  assign in_ready  = reset_n && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_RESULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      ml_drv   <= '0;
      res_data <= '0;
      res_err  <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            ml_drv  <= drv_word;
            timer   <= '0;
            res_err <= 2'b00;
            state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (any_ill) begin
            res_err[1] <= 1'b1;
            res_data   <= '0;
            ml_drv     <= '0;
            timer      <= '0;
            state      <= ST_DRAIN;
          end else if (all_full) begin
            res_data <= rs_hi;
            ml_drv   <= '0;
            timer    <= '0;
            state    <= ST_DRAIN;
          end else if (timeout_hit) begin
            res_err[0] <= 1'b1;
            res_data   <= '0;
            ml_drv     <= '0;
            timer      <= '0;
            state      <= ST_DRAIN;
          end else if (!(&timer)) begin
            timer <= timer + 1'b1;
          end
        end
        ST_DRAIN: begin
          ml_drv <= '0;
          if (all_empty) begin
            state <= ST_RESULT;
          end else begin
            // a stuck-illegal lane must still be able to time out of DRAIN
            if (any_ill) res_err[1] <= 1'b1;
            if (timeout_hit) begin
              res_err[0] <= 1'b1;
              state      <= ST_RESULT;
            end else if (!(&timer)) begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: begin
          if (res_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
